// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: MSB-first shift-and-add multiplier that sequences a shared Hack-style ALU.
// Optional macro ALU_MUL_SKIP_EN starts at the highest set multiplier bit and short-circuits b==0.
module alu_mul_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic             out_zr,
  output logic             out_ng,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zr,
  input  logic             alu_ng
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DBL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] acc_r, acc_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic [CNT_W-1:0] idx_r, idx_s;
  logic             zr_r, zr_s;
  logic             ng_r, ng_s;
  logic [WIDTH-1:0] alu_x_s, alu_y_s;
  logic             alu_f_s;

`ifdef ALU_MUL_SKIP_EN
  // Index of the most significant set bit; zero when no bit is set.
  function automatic logic [CNT_W-1:0] msb_index(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] r;
    r = {CNT_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) r = CNT_W'(i);
    end
    return r;
  endfunction
`endif

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign out_p     = acc_r;
  assign out_zr    = zr_r;
  assign out_ng    = ng_r;
  assign alu_x     = alu_x_s;
  assign alu_y     = alu_y_s;
  assign alu_f     = alu_f_s;
  // Only x+y is ever requested, so the remaining control bits stay low.
  assign alu_zx    = 1'b0;
  assign alu_nx    = 1'b0;
  assign alu_zy    = 1'b0;
  assign alu_ny    = 1'b0;
  assign alu_no    = 1'b0;

  // Next-state, datapath update and ALU drive for the multiply sequence.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    a_s     = a_r;
    b_s     = b_r;
    idx_s   = idx_r;
    zr_s    = zr_r;
    ng_s    = ng_r;
    alu_x_s = {WIDTH{1'b0}};
    alu_y_s = {WIDTH{1'b0}};
    alu_f_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          a_s   = in_a;
          b_s   = in_b;
          acc_s = {WIDTH{1'b0}};
`ifdef ALU_MUL_SKIP_EN
          if (in_b == {WIDTH{1'b0}}) begin
            idx_s   = {CNT_W{1'b0}};
            zr_s    = 1'b1;
            ng_s    = 1'b0;
            state_s = DONE;
          end else begin
            idx_s   = msb_index(in_b);
            state_s = DBL;
          end
`else
          idx_s   = CNT_W'(WIDTH - 1);
          state_s = DBL;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      DBL: begin
        alu_x_s = acc_r;
        alu_y_s = acc_r;
        alu_f_s = 1'b1;
        acc_s   = alu_out;
        zr_s    = alu_zr;
        ng_s    = alu_ng;
        // The ADD step for this bit owns the index decrement.
        if (b_r[idx_r]) begin
          state_s = ADD;
        end else if (idx_r == {CNT_W{1'b0}}) begin
          state_s = DONE;
        end else begin
          idx_s = idx_r - CNT_W'(1);
        end
      end
      ADD: begin
        alu_x_s = acc_r;
        alu_y_s = a_r;
        alu_f_s = 1'b1;
        acc_s   = alu_out;
        zr_s    = alu_zr;
        ng_s    = alu_ng;
        if (idx_r == {CNT_W{1'b0}}) begin
          state_s = DONE;
        end else begin
          idx_s   = idx_r - CNT_W'(1);
          state_s = DBL;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      acc_r   <= {WIDTH{1'b0}};
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      idx_r   <= {CNT_W{1'b0}};
      zr_r    <= 1'b0;
      ng_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      a_r     <= a_s;
      b_r     <= b_s;
      idx_r   <= idx_s;
      zr_r    <= zr_s;
      ng_r    <= ng_s;
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer with a behavioural Hack ALU and product/latency model.
module tb_alu_mul_sequencer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = 16'd0;
  logic [W-1:0] in_b = 16'd0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_p;
  logic         out_zr, out_ng;
  logic [W-1:0] alu_x, alu_y, alu_out;
  logic         alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;

  alu_mul_sequencer #(.WIDTH(W), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_zr(out_zr), .out_ng(out_ng),
    .alu_x(alu_x), .alu_y(alu_y), .alu_zx(alu_zx), .alu_nx(alu_nx),
    .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
  );

  always #5 clk = ~clk;

  // Hack ALU behaviour
  logic [W-1:0] ax, ay, ao;
  always_comb begin
    ax = alu_zx ? 16'd0 : alu_x;
    ax = alu_nx ? ~ax : ax;
    ay = alu_zy ? 16'd0 : alu_y;
    ay = alu_ny ? ~ay : ay;
    ao = alu_f ? (ax + ay) : (ax & ay);
    ao = alu_no ? ~ao : ao;
    alu_out = ao;
    alu_zr  = (ao == 16'd0);
    alu_ng  = ao[15];
  end

  typedef struct {
    logic [W-1:0] p;
    logic         zr;
    logic         ng;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   busy = 1'b0;
  bit   seen = 1'b0;
  bit   after_rst = 1'b0;
  int   rdy_mode = 1;  // 0 random, 1 high, 2 low

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc_at);
    exp_t e;
    logic [31:0] full;
    int msb;
    full = a * b;
    e.p  = full[15:0];
    e.zr = (e.p == 16'd0);
    e.ng = e.p[15];
    msb  = -1;
    for (int i = 0; i < W; i++) if (b[i]) msb = i;
`ifdef ALU_MUL_SKIP_EN
    e.lat = (b == 16'd0) ? 0 : (msb + 1 + $countones(b));
`else
    e.lat = W + $countones(b);
`endif
    e.acc_cyc = acc_at;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready driver
  always @(posedge clk) begin
    #2;
    if (rdy_mode == 0) out_ready = 1'($urandom_range(0, 1));
    else out_ready = (rdy_mode == 1);
  end

  // Monitor and scoreboard: samples on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      busy = 1'b0;
      seen = 1'b0;
      after_rst = 1'b1;
    end else begin
      if (after_rst) begin
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_p", {16'd0, out_p}, 32'd0);
        chk("rst_flags", {30'd0, out_zr, out_ng}, 32'd0);
        after_rst = 1'b0;
      end
      chk("in_ready", {31'd0, in_ready}, {31'd0, !busy});
      if (busy && !out_valid) begin
        chk("alu_ctl_busy", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'h2);
      end else begin
        chk("alu_ctl_idle", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'h0);
        chk("alu_xy_idle", {alu_x, alu_y}, 32'h0);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          if (!seen) begin
            chk("latency", cyc - sb[0].acc_cyc, sb[0].lat);
            seen = 1'b1;
          end
          chk("out_p", {16'd0, out_p}, {16'd0, sb[0].p});
          chk("out_zr", {31'd0, out_zr}, {31'd0, sb[0].zr});
          chk("out_ng", {31'd0, out_ng}, {31'd0, sb[0].ng});
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
            busy = 1'b0;
          end
        end
      end else if (seen) begin
        chk("valid_held", {31'd0, out_valid}, 32'd1);
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_a, in_b, cyc + 1));
        busy = 1'b1;
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!got) chk("accept_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("done_timeout", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    send(16'd3, 16'd5);            wait_done();
    send(16'hFFFF, 16'hFFFF);      wait_done();
    send(16'h0100, 16'h0100);      wait_done();
    send(16'h1234, 16'h0000);      wait_done();

    // Back-pressure: result must hold while out_ready is low
    rdy_mode = 2;
    send(16'd7, 16'hFFFE);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("hold_timeout", {31'd0, ok}, 32'd1);
    repeat (10) @(posedge clk);
    #1 rdy_mode = 1;
    wait_done();

    // New requests while busy must be ignored
    send(16'd5, 16'h8001);
    repeat (10) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    wait_done();

    // Reset during the 6th ALU cycle
    send(16'd9, 16'hFFFF);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    send(16'd2, 16'd3);            wait_done();

    // Randomized traffic with random back-pressure
    rdy_mode = 0;
    for (int t = 0; t < 30; t++) begin
      logic [W-1:0] b;
      b = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'($urandom_range(0, 15));
        1: b = 16'd0;
        default: b = b;
      endcase
      send(16'($urandom), b);
      repeat ($urandom_range(0, 4)) begin
        @(posedge clk); #1;
        in_valid = 1'($urandom_range(0, 1)); in_a = 16'($urandom); in_b = 16'($urandom);
      end
      @(posedge clk); #1 in_valid = 1'b0;
    end
    rdy_mode = 1;
    wait_done();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that computes a 16-bit product by sequencing the shared Hack-style ALU (x, y, zx, nx, zy, ny, f, no, out, zr, ng).
- Uses MSB-first shift-and-add: doubling is done as acc+acc and accumulation as acc+a.
- Owns the ALU operand and control lines while busy. Sits beside the ALU in the arithmetic datapath.
- Valid/ready handshake on both the request side and the result side.

Parameters:
- WIDTH, 16, operand, accumulator and ALU data width.
- CNT_W, 4, bit-index counter width; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  high only in IDLE.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- out_p  output  WIDTH  product, low WIDTH bits (two's-complement wrap).
- out_zr  output  1  ALU zr captured on the final ALU op.
- out_ng  output  1  ALU ng captured on the final ALU op.
- alu_x  output  WIDTH  ALU x operand.
- alu_y  output  WIDTH  ALU y operand.
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  output  1 each  ALU control bits.
- alu_out  input  WIDTH  ALU result, combinational, same cycle.
- alu_zr  input  1  ALU zero flag.
- alu_ng  input  1  ALU negative flag.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - acc, a_reg, b_reg, idx = 0.
  - out_p=0, out_zr=0, out_ng=0, out_valid=0.
  - alu_x=alu_y=0; all ALU control bits 0.
  - in_ready=1 in the first cycle after reset is released.
- States: IDLE, DBL, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: a_reg<=in_a, b_reg<=in_b, acc<=0, idx<=WIDTH-1, go to DBL.
- DBL:
  - Drive alu_x=acc, alu_y=acc, f=1, zx=nx=zy=ny=no=0 (x+y).
  - acc<=alu_out; capture zr/ng<=alu_zr/alu_ng.
  - If b_reg[idx], go to ADD.
  - Else if idx==0, go to DONE.
  - Else idx<=idx-1 and stay in DBL.
- ADD:
  - Drive alu_x=acc, alu_y=a_reg, same x+y control bits.
  - acc<=alu_out; capture zr/ng.
  - If idx==0, go to DONE; else idx<=idx-1 and go to DBL.
- DONE:
  - out_valid=1; out_p=acc, out_zr and out_ng stable.
  - On out_ready, go to IDLE. out_valid stays held while out_ready=0; no data change.
- Latency:
  - Exactly WIDTH+popcount(in_b) ALU cycles between the accept edge and out_valid rising.
  - Example: in_b=5 gives 18 cycles.
- Outside DBL/ADD (IDLE, DONE): alu_x=alu_y=0 and all control bits 0.
- ALU outputs are combinational from state, acc, a_reg and idx. The ALU path is combinational, single cycle.
- in_valid outside IDLE is ignored. The request is not captured; in_ready=0.
- Arithmetic is modulo 2^WIDTH. Overflow wraps silently; signed and unsigned low halves are identical.
- in_b=0 still takes WIDTH DBL cycles; result is 0 with out_zr=1.
- reset mid-operation: return to IDLE next edge with reset values; any partial result is discarded.
- DONE with out_ready already high: one cycle of out_valid, then IDLE. The next request is accepted no earlier than the following cycle.

Optional Feature:
- Macro: ALU_MUL_SKIP_EN.
- Defined:
  - On accept, idx<=index of the highest set bit of in_b (priority encoder), acc<=0.
  - If in_b==0, go directly to DONE with out_p=0, out_zr=1, out_ng=0, using no ALU cycles.
  - Otherwise latency = (msb_index+1)+popcount(in_b) ALU cycles.
- Undefined:
  - Fixed WIDTH doubling cycles as described above.
- Results are identical in both builds; only latency differs.

Test Plan:
- a=3, b=5, out_ready=1:
  - out_p=15, zr=0, ng=0.
  - out_valid rises 18 cycles after accept; with SKIP_EN, 5 cycles.
- a=0xFFFF, b=0xFFFF: out_p=0x0001, ng=0, zr=0; latency 32 ALU cycles.
- a=0x0100, b=0x0100: wrap gives out_p=0x0000, zr=1. Also a=0x1234, b=0: out_p=0, zr=1; with SKIP_EN, DONE the cycle after accept.
- a=7, b=0xFFFE (-2), out_ready held 0 for 10 cycles:
  - out_valid and out_p=0xFFF2, ng=1 stay stable throughout.
  - IDLE is entered one cycle after out_ready=1.
- Pulse in_valid with new operands every cycle while busy: none captured, in_ready=0, the first result is unaffected.
- Assert reset during the 6th ALU cycle:
  - Next cycle: state IDLE, out_valid=0, alu controls 0, in_ready=1.
  - A new request a=2, b=3 then yields 6.
